// File: rtl/chan_hit_counter.sv
// Per-channel rising-edge hit counters with a snapshot-and-stream readout.
// Counting never stops; a readout request freezes all counts into snap and restarts counting.
module chan_hit_counter #(
    parameter int CHANNELS = 10,
    parameter int CNT_W    = 8,
    parameter int CIDX_W   = ($clog2(CHANNELS) < 1) ? 1 : $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [CHANNELS-1:0] ii,
    input  logic                start,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CIDX_W-1:0]   out_chan,
    output logic [CNT_W-1:0]    out_count,
    output logic                out_last
);

    // state | meaning
    // IDLE  | counting only, waiting for start
    // SNAP  | snapshot just taken, one cycle before streaming
    // SEND  | streaming snap[idx] words to the downstream
    typedef enum logic [1:0] {IDLE, SNAP, SEND} state_t;

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CIDX_W-1:0] LAST_IDX = CIDX_W'(CHANNELS - 1);

    state_t                state_q, state_d;
    logic [CIDX_W-1:0]     idx_q, idx_d;
    logic [CHANNELS-1:0]   sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic [CHANNELS-1:0]   hit_edge;
    logic [CNT_W-1:0]      cnt_q  [CHANNELS];
    logic [CNT_W-1:0]      cnt_d  [CHANNELS];
    logic [CNT_W-1:0]      snap_q [CHANNELS];
    logic [CNT_W-1:0]      snap_d [CHANNELS];
    logic                  is_last;

    assign hit_edge = sync2_q & ~sync3_q;
    assign is_last  = (idx_q == LAST_IDX);

    always_comb begin
        sync1_d = ii;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = (hit_edge[i] && (cnt_q[i] != CNT_MAX)) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SNAP;
                    // An edge landing on the snapshot cycle opens the new interval.
                    for (int i = 0; i < CHANNELS; i++) begin
                        snap_d[i] = cnt_q[i];
                        cnt_d[i]  = hit_edge[i] ? CNT_W'(1) : '0;
                    end
                end
            end
            SNAP: begin
                state_d = SEND;
                idx_d   = '0;
            end
            SEND: begin
                if (out_ready) begin
                    if (is_last) state_d = IDLE;
                    else         idx_d   = idx_q + CIDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]  <= '0;
                snap_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]  <= cnt_d[i];
                snap_q[i] <= snap_d[i];
            end
        end
    end

    always_comb begin
        busy      = (state_q != IDLE);
        out_valid = (state_q == SEND);
        out_chan  = out_valid ? idx_q : '0;
        out_count = out_valid ? snap_q[idx_q] : '0;
        out_last  = out_valid && is_last;
    end

endmodule

// File: tb/tb_chan_hit_counter.sv
// Scoreboard bench for chan_hit_counter: pulses are modelled per channel, expected
// words are queued at each readout request and popped as the DUT transfers them.
module tb_chan_hit_counter;

    localparam int CH     = 10;
    localparam int CW     = 8;
    localparam int IW     = 4;
    localparam int CNTMAX = 255;

    typedef struct {
        int  chan;
        int  count;
        bit  last;
    } word_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [CH-1:0] ii = '0;
    logic          start = 1'b0;
    logic          busy;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [IW-1:0] out_chan;
    logic [CW-1:0] out_count;
    logic          out_last;

    int    n_pass = 0;
    int    n_chk  = 0;
    int    exp_cnt [CH];
    word_t sb_q [$];

    chan_hit_counter #(.CHANNELS(CH), .CNT_W(CW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .ii        (ii),
        .start     (start),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan),
        .out_count (out_count),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic pulse(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk); ii[ch] = 1'b1;
            @(negedge clk);
            @(negedge clk); ii[ch] = 1'b0;
            @(negedge clk);
            if (exp_cnt[ch] < CNTMAX) exp_cnt[ch]++;
        end
        repeat (4) @(negedge clk);
    endtask

    // Requests a readout and drains it. pat is the out_ready pattern (repeats every 4 cycles).
    task automatic run_readout(input logic [3:0] pat, input bit poke_start, input bit coincide,
                               input string name);
        int    n;
        int    cyc;
        int    words;
        word_t w;
        if (coincide) begin
            @(negedge clk); ii[2] = 1'b1;
            @(negedge clk);
        end
        for (int i = 0; i < CH; i++) begin
            w.chan  = i;
            w.count = exp_cnt[i];
            w.last  = (i == CH - 1);
            sb_q.push_back(w);
            exp_cnt[i] = 0;
        end
        if (coincide) exp_cnt[2] = 1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n_chk++;
        if (busy !== 1'b1) $display("FAIL %s busy_in_snap got=%b want=1", name, busy);
        else n_pass++;
        n = 0;
        while (out_valid !== 1'b1 && n < 8) begin
            @(negedge clk); n++;
        end
        n_chk++;
        if (out_valid !== 1'b1) begin
            $display("FAIL %s valid_timeout got=%b want=1", name, out_valid);
            sb_q.delete();
            return;
        end
        n_pass++;
        cyc = 0;
        words = 0;
        while (words < CH && cyc < 100) begin
            out_ready = pat[cyc % 4];
            start     = poke_start;
            w = sb_q[0];
            n_chk++;
            if (out_valid !== 1'b1 || out_chan !== IW'(w.chan) || out_count !== CW'(w.count)
                || out_last !== w.last)
                $display("FAIL %s word got v=%b ch=%0d cnt=%0d last=%b want v=1 ch=%0d cnt=%0d last=%b",
                         name, out_valid, out_chan, out_count, out_last, w.chan, w.count, w.last);
            else n_pass++;
            if (out_ready) begin
                void'(sb_q.pop_front());
                words++;
            end
            @(negedge clk);
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        n_chk++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_chan !== '0 || out_count !== '0 || out_last !== 1'b0)
            $display("FAIL %s after_last got v=%b busy=%b ch=%0d cnt=%0d last=%b want all 0",
                     name, out_valid, busy, out_chan, out_count, out_last);
        else n_pass++;
        if (pat == 4'hF) begin
            n_chk++;
            if (cyc !== CH) $display("FAIL %s send_cycles got=%0d want=%0d", name, cyc, CH);
            else n_pass++;
        end
        if (poke_start) begin
            repeat (4) @(negedge clk);
            n_chk++;
            if (busy !== 1'b0) $display("FAIL %s queued_start got busy=%b want=0", name, busy);
            else n_pass++;
        end
        if (coincide) ii[2] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #1;
        n_chk++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_chan !== '0 || out_count !== '0 || out_last !== 1'b0)
            $display("FAIL reset_outputs got busy=%b v=%b ch=%0d cnt=%0d last=%b want all 0",
                     busy, out_valid, out_chan, out_count, out_last);
        else n_pass++;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        fork
            pulse(3, 5);
            pulse(9, 1);
        join
        run_readout(4'hF, 1'b0, 1'b0, "basic");
    endtask

    task automatic test_saturation();
        pulse(0, 300);
        run_readout(4'hF, 1'b0, 1'b0, "saturate");
        run_readout(4'hF, 1'b0, 1'b0, "after_sat");
    endtask

    task automatic test_coincident();
        pulse(2, 4);
        run_readout(4'hF, 1'b0, 1'b1, "coincide");
        run_readout(4'hF, 1'b0, 1'b0, "coincide_next");
    endtask

    task automatic test_backpressure();
        fork
            pulse(1, 2);
            pulse(6, 7);
        join
        run_readout(4'b1001, 1'b1, 1'b0, "backpressure");
    endtask

    task automatic test_back_to_back();
        pulse(5, 3);
        run_readout(4'hF, 1'b0, 1'b0, "b2b_first");
        pulse(4, 2);
        run_readout(4'hF, 1'b0, 1'b0, "b2b_second");
    endtask

    task automatic test_mid_reset();
        int n;
        pulse(8, 2);
        out_ready = 1'b1;
        @(negedge clk); start = 1'b1; ii[1] = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!(out_valid === 1'b1 && out_chan === IW'(4)) && n < 20) begin
            @(negedge clk); n++;
        end
        n_chk++;
        if (out_chan !== IW'(4)) $display("FAIL midreset_reach_idx4 got=%0d want=4", out_chan);
        else n_pass++;
        rstn = 1'b0;
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_count !== '0)
            $display("FAIL midreset_async got v=%b busy=%b cnt=%0d want 0", out_valid, busy, out_count);
        else n_pass++;
        ii[1] = 1'b0;
        for (int i = 0; i < CH; i++) exp_cnt[i] = 0;
        @(negedge clk); rstn = 1'b1;
        repeat (4) @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL midreset_no_words got v=%b busy=%b want 0", out_valid, busy);
        else n_pass++;
        run_readout(4'hF, 1'b0, 1'b0, "midreset_zero");
    endtask

    initial begin
        for (int i = 0; i < CH; i++) exp_cnt[i] = 0;
        test_reset();
        test_basic();
        test_saturation();
        test_coincident();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/chan_hit_counter.md
CHAN_HIT_COUNTER -- requirements
Module: chan_hit_counter

Interface
REQ-001 Parameter CHANNELS, default 10, number of independent input channels (range 2..64).
REQ-002 Parameter CNT_W, default 8, per-channel counter width in bits (range 2..16).
REQ-003 Derived width CIDX_W = ceil(log2(CHANNELS)), minimum 1.
REQ-004 clk  input  1  single clock; every register SHALL be clocked on its rising edge.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 ii  input  CHANNELS  per-channel level signals from the upstream per-channel inverter stage, asynchronous to clk.
REQ-007 start  input  1  readout request, sampled on the rising edge of clk.
REQ-008 busy  output  1  high while a snapshot or readout is in progress.
REQ-009 out_valid  output  1  readout word valid.
REQ-010 out_ready  input  1  downstream accepts the word.
REQ-011 out_chan  output  CIDX_W  channel index of the current word.
REQ-012 out_count  output  CNT_W  snapshotted hit count of out_chan.
REQ-013 out_last  output  1  current word is channel CHANNELS-1.

Function
REQ-014 Each ii bit SHALL pass through a 2-flop synchronizer followed by a third history flop; edge[i] = sync2[i] AND NOT sync3[i].
REQ-015 A rising transition on ii[i] held stable across one clk edge SHALL be reflected in cnt[i] after exactly 3 rising clk edges.
REQ-016 A falling transition SHALL NOT change any counter.
REQ-017 cnt[i] SHALL increment by 1 per edge[i] and saturate at 2^CNT_W-1; it SHALL NOT wrap.
REQ-018 The FSM SHALL have exactly three states: IDLE, SNAP and SEND.
REQ-019 IDLE, start=1 -> SNAP. IDLE, start=0 -> stay in IDLE.
REQ-020 In the IDLE->SNAP clock edge: snap[i] <= cnt[i] for all i, and cnt[i] <= edge[i] ? 1 : 0.
REQ-021 As a consequence of REQ-020, an edge coincident with the snapshot SHALL be counted in the new interval, never lost and never double-counted.
REQ-022 SNAP -> SEND unconditionally after one cycle; idx <= 0.
REQ-023 In SEND: out_valid=1, out_chan=idx, out_count=snap[idx], out_last=(idx==CHANNELS-1).
REQ-024 A transfer SHALL occur on a clock edge where out_valid=1 and out_ready=1.
REQ-025 While out_valid=1 and out_ready=0, out_chan, out_count and out_last SHALL hold stable.
REQ-026 A transfer with out_last=0 SHALL increment idx by 1.
REQ-027 A transfer with out_last=1 SHALL move the FSM to IDLE; out_valid SHALL be 0 in the following cycle.
REQ-028 At most one transfer SHALL occur per cycle; with out_ready held high, a full readout takes CHANNELS cycles in SEND.
REQ-029 busy SHALL be high whenever the state is not IDLE.
REQ-030 start asserted in SNAP or SEND SHALL be ignored and SHALL NOT be queued.
REQ-031 start asserted in the cycle after a last transfer (FSM in IDLE) SHALL be accepted.
REQ-032 Counting per REQ-015..017 SHALL continue in all FSM states.
REQ-033 When out_valid=0, out_chan, out_count and out_last SHALL be driven to 0.

Reset
REQ-034 rstn low SHALL asynchronously clear all sync/history flops, cnt, snap and idx to 0, and set the FSM to IDLE.
REQ-035 Reset value of every output: busy=0, out_valid=0, out_chan=0, out_count=0, out_last=0.
REQ-036 Reset asserted mid-SEND SHALL abort the readout immediately; no further words SHALL be produced after reset is released.
REQ-037 Reset release SHALL be treated as synchronous to clk; the first start is accepted no earlier than the first clk edge with rstn high.

Verification
REQ-038 CHANNELS=10, CNT_W=8: 5 pulses on ii[3], 1 pulse on ii[9], start, out_ready=1 -> 10 words in 10 consecutive cycles; chan3=5, chan9=1, others 0; out_last only on chan 9; busy low after the last word.
REQ-039 300 pulses on ii[0], then readout -> out_count for chan0 = 255 (saturated); a second readout with no new pulses -> all counts 0.
REQ-040 ii[2] edge timed to reach edge[2] in the IDLE->SNAP cycle (cnt[2]=4 before) -> this readout reports 4; the next readout reports 1.
REQ-041 out_ready toggled 1,0,0,1 during SEND -> outputs stable while ready=0, no word skipped or repeated; start pulses during SEND produce no extra readout.
REQ-042 rstn pulsed low while idx=4 in SEND -> out_valid and busy drop asynchronously, counters read 0 on the next readout.
